vx_tensor_hgmma_sched: RTL and testbench
========================================

VX_TENSOR_HGMMA_SCHED -- requirements
Module: VX_tensor_hgmma_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default `NUM_WARPS, number of warps sharing one tensor core.
REQ-002 SHALL have parameter MAX_PENDING, default 2, per-warp limit on queued plus in-flight HGMMAs.
REQ-003 SHALL have port clk  input  1  the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid/req_ready  input/output  1/1  request handshake.
REQ-006 SHALL have port req_wid  input  `NW_WIDTH  issuing warp.
REQ-007 SHALL have port req_wait  input  1  request kind: 1=HGMMA_WAIT, 0=HGMMA.
REQ-008 SHALL have ports init_valid/init_ready  output/input  1/1  tensor-core initiate handshake.
REQ-009 SHALL have port init_wid  output  `NW_WIDTH  warp being initiated.
REQ-010 SHALL have port wb_fire  input  1  tensor-core writeback accepted this cycle.
REQ-011 SHALL have ports wb_wid/wb_last  input  `NW_WIDTH/1  writeback warp and last-beat flag.
REQ-012 SHALL have ports done_valid/done_ready  output/input  1/1  HGMMA_WAIT completion handshake.
REQ-013 SHALL have port done_wid  output  `NW_WIDTH  warp whose wait completed.
REQ-014 SHALL have port busy_mask  output  NUM_WARPS  bit w set iff pend[w]!=0.
REQ-015 SHALL have port err  output  1  sticky protocol error.

Function
REQ-016 SHALL keep per-warp counters pend[w] (queued+in-flight) and qcnt[w] (queued only), each $clog2(MAX_PENDING+1) bits, plus per-warp flag wait_pend[w].
REQ-017 req_ready SHALL be combinational: HGMMA -> pend[req_wid]<MAX_PENDING; WAIT -> !wait_pend[req_wid]; never depends on req_valid.
REQ-018 Accepted HGMMA SHALL increment pend and qcnt of req_wid at the clock edge.
REQ-019 Accepted WAIT SHALL set wait_pend[req_wid].
REQ-020 Controller FSM SHALL have states IDLE and RUN; init_valid SHALL be asserted only in IDLE with some qcnt[w]!=0.
REQ-021 init_wid SHALL be the round-robin grant over {w: qcnt[w]!=0}, searching from pointer rr_ptr upward with wrap; rr_ptr SHALL become grant+1 (mod NUM_WARPS) on init fire.
REQ-022 Init fire SHALL decrement qcnt[init_wid], latch active_wid, and move IDLE->RUN; earliest init_valid is the cycle after HGMMA acceptance.
REQ-023 In RUN, wb_fire&&wb_last&&wb_wid==active_wid SHALL decrement pend[active_wid] and return to IDLE; init_valid SHALL NOT assert in that same cycle.
REQ-024 In RUN, wb_fire with wb_wid!=active_wid SHALL set err; non-last beats SHALL not change state.
REQ-025 In IDLE, wb_fire SHALL be ignored and SHALL not set err.
REQ-026 Same-cycle HGMMA accept and last-writeback on one warp SHALL leave pend unchanged (+1-1).
REQ-027 done_valid SHALL be registered, asserted when some w has wait_pend[w] && pend[w]==0; done_wid SHALL be the lowest such index.
REQ-028 done fire SHALL clear wait_pend[done_wid]; done_wid SHALL hold stable while done_valid&&!done_ready.
REQ-029 A WAIT accepted while pend[w]==0 SHALL yield done_valid on the cycle after acceptance.

Reset
REQ-030 Reset SHALL asynchronously clear pend, qcnt, wait_pend, rr_ptr, active_wid, err, and force IDLE.
REQ-031 Outputs during reset SHALL be: req_ready=1, init_valid=0, init_wid=0, done_valid=0, done_wid=0, busy_mask=0, err=0.
REQ-032 Reset mid-RUN SHALL drop all in-flight bookkeeping; subsequent stale writebacks SHALL be ignored per REQ-025.

Structure
REQ-033 FSM state enum and MAX_PENDING default SHALL reside in VX_gpu_pkg.
REQ-034 Round-robin grant SHALL be one VX_rr_arbiter instance; all other logic is inline.

Verification
REQ-035 W2 issues HGMMA at t0 -> init_valid,init_wid=2 at t0+1; wb_last for W2 -> pend[2]=0, busy_mask=0.
REQ-036 W1, W3 HGMMA back-to-back, init_ready=1 -> grants W1 then W3 in order; never two inits without intervening wb_last.
REQ-037 W0 issues 2 HGMMAs (MAX_PENDING=2) -> third HGMMA from W0 sees req_ready=0 until first wb_last.
REQ-038 W4 WAIT with pend[4]=1 -> done_valid stays 0 until W4 wb_last, then done_valid,done_wid=4 next cycle.
REQ-039 RUN on W5, wb_fire with wb_wid=6 -> err=1, stays 1 until reset.
REQ-040 Assert reset mid-RUN with qcnt[1]=1 -> all outputs at reset values; wb_last afterwards changes nothing, err=0.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// ============================================================================
//  Module      : VX_gpu_pkg
//  Description : Shared types and defaults for the HGMMA tensor-core scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package VX_gpu_pkg;

    localparam int NUM_WARPS_DEF   = 8;
    localparam int MAX_PENDING_DEF = 2;

    typedef enum logic [0:0] {
        HG_IDLE = 1'b0,
        HG_RUN  = 1'b1
    } hgmma_state_e;

    // Index width that never collapses to zero bits for a single warp.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/VX_rr_arbiter.sv
// ============================================================================
//  Module      : VX_rr_arbiter
//  Description : Combinational round-robin grant, searching upward from i_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module VX_rr_arbiter #(
    parameter int NUM_REQS = 8,
    parameter int IDX_W    = 3
) (
    input  logic [NUM_REQS-1:0] i_req,
    input  logic [IDX_W-1:0]    i_ptr,
    output logic                o_valid,
    output logic [IDX_W-1:0]    o_grant
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_valid = |i_req;
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQS;
            if (!w_found && i_req[IDX_W'(w_idx)]) begin
                w_found = 1'b1;
                o_grant = IDX_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vx_tensor_hgmma_sched.sv
// ============================================================================
//  Module      : vx_tensor_hgmma_sched
//  Description : Per-warp HGMMA queueing, round-robin tensor-core initiation
//                and HGMMA_WAIT completion tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_tensor_hgmma_sched
    import VX_gpu_pkg::*;
#(
    parameter int  NUM_WARPS   = NUM_WARPS_DEF,
    parameter int  MAX_PENDING = MAX_PENDING_DEF,
    localparam int NW_WIDTH    = clog2_min1(NUM_WARPS),
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_WIDTH-1:0]  req_wid,
    input  logic                 req_wait,

    output logic                 init_valid,
    input  logic                 init_ready,
    output logic [NW_WIDTH-1:0]  init_wid,

    input  logic                 wb_fire,
    input  logic [NW_WIDTH-1:0]  wb_wid,
    input  logic                 wb_last,

    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [NW_WIDTH-1:0]  done_wid,

    output logic [NUM_WARPS-1:0] busy_mask,
    output logic                 err
);

    localparam logic [CNT_W-1:0]    c_max_pend = CNT_W'(MAX_PENDING);
    localparam logic [NW_WIDTH-1:0] c_last_wid = NW_WIDTH'(NUM_WARPS - 1);

    hgmma_state_e                    r_state;
    logic [NUM_WARPS-1:0][CNT_W-1:0] r_pend;
    logic [NUM_WARPS-1:0][CNT_W-1:0] r_qcnt;
    logic [NUM_WARPS-1:0]            r_wait_pend;
    logic [NW_WIDTH-1:0]             r_rr_ptr;
    logic [NW_WIDTH-1:0]             r_active_wid;
    logic                            r_err;
    logic                            r_done_valid;
    logic [NW_WIDTH-1:0]             r_done_wid;

    logic [NUM_WARPS-1:0][CNT_W-1:0] w_pend_nxt;
    logic [NUM_WARPS-1:0][CNT_W-1:0] w_qcnt_nxt;
    logic [NUM_WARPS-1:0]            w_wait_nxt;
    logic [NUM_WARPS-1:0]            w_q_nz;
    logic [NUM_WARPS-1:0]            w_done_cand;
    logic [NUM_WARPS-1:0]            w_hg_sel, w_wt_sel, w_init_sel, w_wb_sel, w_done_sel;
    logic                            w_any_q;
    logic [NW_WIDTH-1:0]             w_grant;
    logic [NW_WIDTH-1:0]             w_grant_nxt;
    logic                            w_hg_fire, w_wt_fire, w_init_fire, w_done_fire;
    logic                            w_run, w_wb_done, w_wb_err;
    logic                            w_done_any;
    logic [NW_WIDTH-1:0]             w_done_idx;

    VX_rr_arbiter #(
        .NUM_REQS (NUM_WARPS),
        .IDX_W    (NW_WIDTH)
    ) u_rr_arb (
        .i_req   (w_q_nz),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_any_q),
        .o_grant (w_grant)
    );

    // Ready is a pure function of the request fields, never of req_valid.
    assign req_ready = req_wait ? !r_wait_pend[req_wid] : (r_pend[req_wid] < c_max_pend);

    assign w_run       = (r_state == HG_RUN);
    assign init_valid  = !w_run && w_any_q;
    assign init_wid    = init_valid ? w_grant : '0;
    assign w_grant_nxt = (w_grant == c_last_wid) ? '0 : w_grant + 1'b1;

    assign w_hg_fire   = req_valid && req_ready && !req_wait;
    assign w_wt_fire   = req_valid && req_ready && req_wait;
    assign w_init_fire = init_valid && init_ready;
    assign w_done_fire = r_done_valid && done_ready;
    assign w_wb_err    = w_run && wb_fire && (wb_wid != r_active_wid);
    assign w_wb_done   = w_run && wb_fire && wb_last && (wb_wid == r_active_wid);

    assign w_hg_sel   = w_hg_fire   ? (NUM_WARPS'(1) << req_wid)      : '0;
    assign w_wt_sel   = w_wt_fire   ? (NUM_WARPS'(1) << req_wid)      : '0;
    assign w_init_sel = w_init_fire ? (NUM_WARPS'(1) << w_grant)      : '0;
    assign w_wb_sel   = w_wb_done   ? (NUM_WARPS'(1) << r_active_wid) : '0;
    assign w_done_sel = w_done_fire ? (NUM_WARPS'(1) << r_done_wid)   : '0;

    assign w_wait_nxt = (r_wait_pend & ~w_done_sel) | w_wt_sel;

    for (genvar gw = 0; gw < NUM_WARPS; gw++) begin : g_warp
        assign w_pend_nxt[gw]  = r_pend[gw] + CNT_W'(w_hg_sel[gw]) - CNT_W'(w_wb_sel[gw]);
        assign w_qcnt_nxt[gw]  = r_qcnt[gw] + CNT_W'(w_hg_sel[gw]) - CNT_W'(w_init_sel[gw]);
        assign w_q_nz[gw]      = (r_qcnt[gw] != '0);
        assign busy_mask[gw]   = (r_pend[gw] != '0);
        // Judged on next-state so a WAIT on an idle warp completes one cycle later.
        assign w_done_cand[gw] = w_wait_nxt[gw] && (w_pend_nxt[gw] == '0);
    end

    always_comb begin
        w_done_any = |w_done_cand;
        w_done_idx = '0;
        for (int w = NUM_WARPS - 1; w >= 0; w--) begin
            if (w_done_cand[NW_WIDTH'(w)]) begin
                w_done_idx = NW_WIDTH'(w);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= HG_IDLE;
            r_pend       <= '0;
            r_qcnt       <= '0;
            r_wait_pend  <= '0;
            r_rr_ptr     <= '0;
            r_active_wid <= '0;
            r_err        <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_wid   <= '0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_qcnt      <= w_qcnt_nxt;
            r_wait_pend <= w_wait_nxt;

            case (r_state)
                HG_IDLE: begin
                    if (w_init_fire) begin
                        r_state      <= HG_RUN;
                        r_active_wid <= w_grant;
                        r_rr_ptr     <= w_grant_nxt;
                    end
                end
                HG_RUN: begin
                    if (w_wb_err) begin
                        r_err <= 1'b1;
                    end else if (w_wb_done) begin
                        r_state <= HG_IDLE;
                    end
                end
                default: r_state <= HG_IDLE;
            endcase

            // A presented completion is held until the consumer takes it.
            if (!(r_done_valid && !done_ready)) begin
                r_done_valid <= w_done_any;
                r_done_wid   <= w_done_idx;
            end
        end
    end

    assign done_valid = r_done_valid;
    assign done_wid   = r_done_wid;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vx_tensor_hgmma_sched.sv
// ============================================================================
//  Module      : tb_vx_tensor_hgmma_sched
//  Description : Directed and randomized bench with a per-cycle reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_tensor_hgmma_sched;

    localparam int NW = 8;
    localparam int MP = 2;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_wait;
    logic [WW-1:0] req_wid;
    logic          init_valid, init_ready;
    logic [WW-1:0] init_wid;
    logic          wb_fire, wb_last;
    logic [WW-1:0] wb_wid;
    logic          done_valid, done_ready;
    logic [WW-1:0] done_wid;
    logic [NW-1:0] busy_mask;
    logic          err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_pend [NW];
    int m_qcnt [NW];
    bit m_wait [NW];
    int m_rr, m_active, m_dw;
    bit m_run, m_err, m_dv;

    vx_tensor_hgmma_sched #(.NUM_WARPS(NW), .MAX_PENDING(MP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wid    (req_wid),
        .req_wait   (req_wait),
        .init_valid (init_valid),
        .init_ready (init_ready),
        .init_wid   (init_wid),
        .wb_fire    (wb_fire),
        .wb_wid     (wb_wid),
        .wb_last    (wb_last),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_wid   (done_wid),
        .busy_mask  (busy_mask),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit f_ready();
        if (req_wait) return !m_wait[req_wid];
        return m_pend[req_wid] < MP;
    endfunction

    function automatic int f_grant();
        for (int k = 0; k < NW; k++) begin
            if (m_qcnt[(m_rr + k) % NW] > 0) return (m_rr + k) % NW;
        end
        return -1;
    endfunction

    function automatic bit m_busy();
        bit b = m_dv;
        for (int w = 0; w < NW; w++) b |= (m_pend[w] != 0) || m_wait[w];
        return b;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_pend[w] = 0; m_qcnt[w] = 0; m_wait[w] = 0;
        end
        m_rr = 0; m_active = 0; m_dw = 0;
        m_run = 0; m_err = 0; m_dv = 0;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        bit rdy   = f_ready();
        int g     = f_grant();
        bit iv    = !m_run && (g >= 0);
        bit hg    = req_valid && rdy && !req_wait;
        bit wt    = req_valid && rdy && req_wait;
        bit dfire = m_dv && done_ready;
        bit wbl   = 0;
        if (m_run && wb_fire) begin
            if (int'(wb_wid) != m_active) m_err = 1;
            else if (wb_last) wbl = 1;
        end
        if (hg) begin m_pend[req_wid]++; m_qcnt[req_wid]++; end
        if (wt) m_wait[req_wid] = 1;
        if (dfire) m_wait[m_dw] = 0;
        if (wbl) begin m_pend[m_active]--; m_run = 0; end
        if (iv && init_ready) begin
            m_qcnt[g]--; m_active = g; m_rr = (g + 1) % NW; m_run = 1;
        end
        if (!(m_dv && !done_ready)) begin
            m_dv = 0; m_dw = 0;
            for (int w = 0; w < NW; w++) begin
                if (!m_dv && m_wait[w] && m_pend[w] == 0) begin m_dv = 1; m_dw = w; end
            end
        end
    endtask

    task automatic check_outputs();
        int            g  = f_grant();
        bit            iv = !m_run && (g >= 0);
        logic [NW-1:0] bm;
        for (int w = 0; w < NW; w++) bm[w] = (m_pend[w] != 0);
        chk("req_ready",  req_ready,  f_ready());
        chk("init_valid", init_valid, iv);
        chk("init_wid",   init_wid,   iv ? g : 0);
        chk("done_valid", done_valid, m_dv);
        chk("done_wid",   done_wid,   m_dw);
        chk("busy_mask",  busy_mask,  bm);
        chk("err",        err,        m_err);
    endtask

    task automatic idle();
        req_valid = 0; req_wid = 0; req_wait = 0;
        init_ready = 0; done_ready = 0;
        wb_fire = 0; wb_wid = 0; wb_last = 0;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic req(input int wid, input bit is_wait);
        req_valid = 1; req_wid = WW'(wid); req_wait = is_wait;
    endtask

    task automatic wb(input int wid, input bit last);
        wb_fire = 1; wb_wid = WW'(wid); wb_last = last;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        model_reset();
        #1;
        chk("rst_req_ready",  req_ready,  1);
        chk("rst_init_valid", init_valid, 0);
        chk("rst_init_wid",   init_wid,   0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_wid",   done_wid,   0);
        chk("rst_busy_mask",  busy_mask,  0);
        chk("rst_err",        err,        0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && m_busy(); i++) begin
            idle();
            init_ready = 1; done_ready = 1;
            if (m_run) wb(m_active, 1);
            tick();
        end
        idle();
        #1 chk("drain_busy", busy_mask, 0);
    endtask

    initial begin
        idle();
        reset = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single HGMMA on W2: initiated next cycle, cleared by its last writeback.
        req(2, 0); tick();
        idle(); #1 chk("w2_init_valid", init_valid, 1); chk("w2_init_wid", init_wid, 2);
        init_ready = 1; tick();
        idle(); #1 chk("w2_busy", busy_mask, 8'h04);
        wb(2, 1); tick();
        idle(); #1 chk("w2_busy_clr", busy_mask, 0);

        // W1 then W3 back-to-back: W1 granted first, W3 only after W1 completes.
        init_ready = 1; req(1, 0); tick();
        req(3, 0); init_ready = 1; tick();
        idle(); init_ready = 1; #1 chk("w13_no_second_init", init_valid, 0);
        wb(1, 1); #1 chk("w13_no_init_on_wb", init_valid, 0);
        tick();
        idle(); init_ready = 1; #1 chk("w13_init_valid", init_valid, 1); chk("w13_init_wid", init_wid, 3);
        tick();
        idle(); wb(3, 1); tick();
        idle();

        // W0 fills its pending budget; third request waits for a writeback.
        req(0, 0); tick();
        tick();
        #1 chk("w0_full", req_ready, 0);
        init_ready = 1; tick();
        init_ready = 0; #1 chk("w0_still_full", req_ready, 0);
        wb(0, 1); tick();
        wb_fire = 0; wb_last = 0; #1 chk("w0_space", req_ready, 1);
        tick();
        drain();

        // WAIT on busy W4 completes only after W4's last writeback.
        idle(); req(4, 0); tick();
        idle(); init_ready = 1; tick();
        idle(); req(4, 1); tick();
        idle(); done_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("w4_wait_hold", done_valid, 0);
            tick();
        end
        wb(4, 1); tick();
        idle(); #1 chk("w4_done_valid", done_valid, 1); chk("w4_done_wid", done_wid, 4);
        done_ready = 1; tick();
        idle(); #1 chk("w4_done_clr", done_valid, 0);

        // WAIT on an idle warp completes the very next cycle.
        req(7, 1); tick();
        idle(); #1 chk("w7_done_valid", done_valid, 1); chk("w7_done_wid", done_wid, 7);
        done_ready = 1; tick();
        idle();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            req_valid  = ($urandom % 2) == 0;
            req_wid    = WW'($urandom % NW);
            req_wait   = ($urandom % 5) == 0;
            init_ready = ($urandom % 2) == 0;
            done_ready = ($urandom % 2) == 0;
            if (m_run) begin
                wb_fire = ($urandom % 2) == 0;
                wb_wid  = WW'(m_active);
                wb_last = ($urandom % 3) == 0;
            end else begin
                wb_fire = ($urandom % 4) == 0;
                wb_wid  = WW'($urandom % NW);
                wb_last = ($urandom % 2) == 0;
            end
            tick();
        end
        drain();

        // Writeback from the wrong warp while W5 runs: sticky error.
        idle(); req(5, 0); tick();
        idle(); init_ready = 1; tick();
        idle(); wb(6, 1); tick();
        idle(); #1 chk("err_set", err, 1);
        for (int i = 0; i < 3; i++) begin
            wb(5, 1); tick();
        end
        idle(); #1 chk("err_sticky", err, 1);

        // Reset while W1 runs with one more queued; stale writeback ignored.
        do_reset();
        req(1, 0); tick();
        tick();
        idle(); init_ready = 1; tick();
        idle();
        do_reset();
        wb(1, 1); tick();
        idle(); #1;
        chk("post_rst_busy", busy_mask, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_init", init_valid, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
